// File: rtl/bit_sequencer8.sv
// bit_sequencer8: takes one packed WIDTH-bit word on a valid/ready port and
// issues it one bit per accepted beat with its bit index and a last flag.
// WIDTH must be at least 2.
// LSB_FIRST selects the issue order (0..WIDTH-1 or WIDTH-1..0).
// ZERO_SKIP limits the beats to the bits that are set.
// Every output is a register, so there is no combinational path from in_* to out_*.
module bit_sequencer8 #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int ZERO_SKIP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_bit,
    output logic [$clog2(WIDTH)-1:0]   out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int             IW  = $clog2(WIDTH);
    localparam logic [IW-1:0]  TOP = IW'(WIDTH - 1);
    localparam logic [IW:0]    ONE = (IW+1)'(1);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t           state;
    logic [WIDTH-1:0] word;      // captured word; in_data is ignored while sequencing
    logic [IW-1:0]    nxt_pos;   // issue-order position of the beat after the current one

    logic [IW:0]      cap_first;   // {found, pos} of the first beat of in_data
    logic [IW:0]      cap_second;  // {found, pos} of the beat following cap_first
    logic [IW:0]      adv_next;    // {found, pos} of the beat following nxt_pos

    // Positions count 0..WIDTH-1 in issue order; map a position to a bit index.
    function automatic logic [IW-1:0] pos_to_idx(input logic [IW-1:0] p);
        return (LSB_FIRST != 0) ? p : TOP - p;
    endfunction

    // Find the earliest issue position >= start that produces a beat.
    // Returns {found, pos}; the found bit is clear when nothing remains.
    function automatic logic [IW:0] seek(input logic [WIDTH-1:0] w,
                                         input logic [IW:0]      start);
        logic [IW:0]   res;
        logic [IW-1:0] pw;
        res = '0;
        for (int p = WIDTH - 1; p >= 0; p--) begin
            pw = IW'(p);
            if ((p >= int'(start)) && ((ZERO_SKIP == 0) || w[pos_to_idx(pw)]))
                res = {1'b1, pw};
        end
        return res;
    endfunction

    // Look-ahead on the incoming word and on the held word for the next beat and the last flag.
    always_comb begin
        cap_first  = seek(in_data, '0);
        cap_second = seek(in_data, {1'b0, cap_first[IW-1:0]} + ONE);
        adv_next   = seek(word, {1'b0, nxt_pos} + ONE);
    end

    // Two-state sequencer with registered handshake and beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word      <= '0;
            nxt_pos   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word <= in_data;
                        if (cap_first[IW]) begin
                            state     <= SEQ;
                            nxt_pos   <= cap_second[IW-1:0];
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_bit   <= in_data[pos_to_idx(cap_first[IW-1:0])];
                            out_idx   <= pos_to_idx(cap_first[IW-1:0]);
                            out_last  <= ~cap_second[IW];
                            busy      <= 1'b1;
                        end else begin
                            // Zero word with zero skipping: no beats, report completion.
                            done <= 1'b1;
                        end
                    end
                end
                SEQ: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            nxt_pos   <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_bit   <= 1'b0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            nxt_pos  <= adv_next[IW-1:0];
                            out_bit  <= word[pos_to_idx(nxt_pos)];
                            out_idx  <= pos_to_idx(nxt_pos);
                            out_last <= ~adv_next[IW];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_sequencer8.sv
// Testbench for bit_sequencer8.
// All four LSB_FIRST/ZERO_SKIP variants share one stimulus stream.
// A queue-based model gives the expected beats of each variant.
module tb_bit_sequencer8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic [3:0] rdy, ov, ob, ol, bz, dn;
    logic [2:0] oi [4];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instance k: LSB_FIRST = (k even), ZERO_SKIP = (k >= 2)
    for (genvar g = 0; g < 4; g++) begin : g_dut
        bit_sequencer8 #(
            .WIDTH(8),
            .LSB_FIRST(((g % 2) == 0) ? 1 : 0),
            .ZERO_SKIP(g / 2)
        ) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(rdy[g]), .in_data(in_data),
            .out_valid(ov[g]), .out_ready(out_ready),
            .out_bit(ob[g]), .out_idx(oi[g]), .out_last(ol[g]),
            .busy(bz[g]), .done(dn[g])
        );
    end

    function automatic bit lsb_of(int k); return (k % 2) == 0; endfunction
    function automatic bit zs_of(int k);  return k >= 2;       endfunction
    function automatic int order_idx(int k, int i); return lsb_of(k) ? i : 7 - i; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: the remaining beats of each instance are a queue of bit indices
    int         q  [4][$];
    logic [7:0] mw [4];
    bit         mdone [4];

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                q[k].delete();
                mdone[k] = 1'b0;
            end else if (q[k].size() == 0) begin
                mdone[k] = 1'b0;
                if (in_valid) begin
                    mw[k] = in_data;
                    for (int i = 0; i < 8; i++)
                        if (!zs_of(k) || in_data[order_idx(k, i)]) q[k].push_back(order_idx(k, i));
                    if (q[k].size() == 0) mdone[k] = 1'b1;
                end
            end else begin
                mdone[k] = 1'b0;
                if (out_ready) begin
                    void'(q[k].pop_front());
                    if (q[k].size() == 0) mdone[k] = 1'b1;
                end
            end
        end
    end

    // Beat and done logs used by the directed checks
    int lg_idx [4][$];
    int lg_bit [4][$];
    int lg_last[4][$];
    int lg_cyc [4][$];
    int dn_cyc [4][$];
    int fv     [4];
    bit ev;

    // On every falling edge, compare each instance with the model and log handshakes
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                ev = q[k].size() > 0;
                chk($sformatf("i%0d.in_ready", k),  rdy[k], !ev);
                chk($sformatf("i%0d.out_valid", k), ov[k],  ev);
                chk($sformatf("i%0d.busy", k),      bz[k],  ev);
                chk($sformatf("i%0d.done", k),      dn[k],  mdone[k]);
                if (ev) begin
                    chk($sformatf("i%0d.out_idx", k),  oi[k], q[k][0]);
                    chk($sformatf("i%0d.out_bit", k),  ob[k], mw[k][q[k][0]]);
                    chk($sformatf("i%0d.out_last", k), ol[k], q[k].size() == 1);
                end
                if (!rst && ov[k] && out_ready) begin
                    lg_idx[k].push_back(int'(oi[k]));
                    lg_bit[k].push_back(int'(ob[k]));
                    lg_last[k].push_back(int'(ol[k]));
                    lg_cyc[k].push_back(cyc);
                end
                if (ov[k] && fv[k] < 0) fv[k] = cyc;
                if (dn[k]) dn_cyc[k].push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 4; k++) begin
            lg_idx[k].delete(); lg_bit[k].delete(); lg_last[k].delete();
            lg_cyc[k].delete(); dn_cyc[k].delete(); fv[k] = -1;
        end
    endtask

    // Pack the logged beats of an instance: count, bits in issue order, first/final index,
    // number of last flags and the beat position that carried the last flag.
    task automatic summ(input int k, output int cnt, output int bits, output int first,
                        output int fin, output int lcnt, output int lpos);
        cnt = lg_idx[k].size(); bits = 0; first = -1; fin = -1; lcnt = 0; lpos = -1;
        for (int i = 0; i < cnt; i++) begin
            bits = (bits << 1) | lg_bit[k][i];
            if (i == 0) first = lg_idx[k][i];
            fin = lg_idx[k][i];
            if (lg_last[k][i] != 0) begin lcnt++; lpos = i; end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bz != 4'b0 && n < 100) begin
            step();
            n++;
        end
        chk({name, ".idle_timeout"}, n < 100, 1);
    endtask

    int drv_cyc;

    // One word, single-cycle in_valid. mode 0: out_ready high, mode 1: out_ready toggles.
    task automatic run_word(input logic [7:0] d, input int mode, input string name);
        int n;
        clear_logs();
        drv_cyc  = cyc;
        in_valid = 1'b1;
        in_data  = d;
        out_ready = (mode == 1) ? 1'b0 : 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (bz != 4'b0 && n < 100) begin
            in_data   = 8'($urandom);
            out_ready = (mode == 1) ? ~out_ready : 1'b1;
            step();
            n++;
        end
        chk({name, ".idle_timeout"}, n < 100, 1);
        out_ready = 1'b1;
        step();
    endtask

    task automatic reset_state(input int k, input string name);
        chk($sformatf("%s.i%0d.in_ready", name, k),  rdy[k], 1);
        chk($sformatf("%s.i%0d.out_valid", name, k), ov[k],  0);
        chk($sformatf("%s.i%0d.out_bit", name, k),   ob[k],  0);
        chk($sformatf("%s.i%0d.out_idx", name, k),   oi[k],  0);
        chk($sformatf("%s.i%0d.out_last", name, k),  ol[k],  0);
        chk($sformatf("%s.i%0d.busy", name, k),      bz[k],  0);
        chk($sformatf("%s.i%0d.done", name, k),      dn[k],  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cnt, bits, first, fin, lcnt, lpos;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        clear_logs();
        step();
        chk_en = 1'b1;
        step();
        for (int k = 0; k < 4; k++) reset_state(k, "reset");
        rst = 1'b0;
        step();

        // Test 1: 0xA5, LSB first, no skipping
        run_word(8'hA5, 0, "t1");
        summ(0, cnt, bits, first, fin, lcnt, lpos);
        chk("t1.count", cnt, 8);
        chk("t1.bits", bits, 32'hA5);
        chk("t1.first_idx", first, 0);
        chk("t1.final_idx", fin, 7);
        chk("t1.last_count", lcnt, 1);
        chk("t1.last_pos", lpos, 7);
        chk("t1.first_latency", fv[0] - drv_cyc, 1);
        chk("t1.done_count", dn_cyc[0].size(), 1);
        chk("t1.done_delay", dn_cyc[0].size() == 1 ? dn_cyc[0][0] - lg_cyc[0][cnt-1] : -1, 1);

        // Test 2: 0x81, MSB first
        run_word(8'h81, 0, "t2");
        summ(1, cnt, bits, first, fin, lcnt, lpos);
        chk("t2.count", cnt, 8);
        chk("t2.bits", bits, 32'h81);
        chk("t2.first_idx", first, 7);
        chk("t2.final_idx", fin, 0);

        // Test 3: zero skipping on 0x24, then a zero word
        run_word(8'h24, 0, "t3");
        summ(2, cnt, bits, first, fin, lcnt, lpos);
        chk("t3.count", cnt, 2);
        chk("t3.bits", bits, 3);
        chk("t3.first_idx", first, 2);
        chk("t3.final_idx", fin, 5);
        chk("t3.last_pos", lpos, 1);
        summ(3, cnt, bits, first, fin, lcnt, lpos);
        chk("t3.msb.first_idx", first, 5);
        chk("t3.msb.final_idx", fin, 2);

        run_word(8'h00, 0, "t3b");
        summ(2, cnt, bits, first, fin, lcnt, lpos);
        chk("t3b.count", cnt, 0);
        chk("t3b.no_valid", fv[2], -1);
        chk("t3b.done_count", dn_cyc[2].size(), 1);
        chk("t3b.done_delay", dn_cyc[2].size() == 1 ? dn_cyc[2][0] - drv_cyc : -1, 1);
        summ(0, cnt, bits, first, fin, lcnt, lpos);
        chk("t3b.full.count", cnt, 8);
        chk("t3b.full.bits", bits, 0);

        // Test 4: backpressure, out_ready toggling on 0x3C
        run_word(8'h3C, 1, "t4");
        summ(0, cnt, bits, first, fin, lcnt, lpos);
        chk("t4.count", cnt, 8);
        chk("t4.bits", bits, 32'h3C);
        chk("t4.final_idx", fin, 7);
        summ(2, cnt, bits, first, fin, lcnt, lpos);
        chk("t4.skip.count", cnt, 4);
        chk("t4.skip.bits", bits, 32'hF);
        chk("t4.skip.first_idx", first, 2);

        // Test 5: back-to-back words with in_valid held high
        begin
            int n;
            clear_logs();
            in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
            step();
            in_data = 8'h01;
            n = 0;
            while (!rdy[0] && n < 50) begin step(); n++; end
            chk("t5.ready_timeout", n < 50, 1);
            step();
            in_valid = 1'b0;
            wait_idle("t5");
            step();
        end
        summ(0, cnt, bits, first, fin, lcnt, lpos);
        chk("t5.count", cnt, 16);
        chk("t5.bits", bits, 32'hFF80);
        chk("t5.gap", cnt == 16 ? lg_cyc[0][8] - lg_cyc[0][7] : -1, 2);
        chk("t5.done_count", dn_cyc[0].size(), 2);
        summ(2, cnt, bits, first, fin, lcnt, lpos);
        chk("t5.skip.count", cnt, 9);

        // Test 6: reset after three accepted beats
        clear_logs();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        reset_state(0, "t6");
        reset_state(2, "t6");
        rst = 1'b0;
        step();
        summ(0, cnt, bits, first, fin, lcnt, lpos);
        chk("t6.count", cnt, 3);
        chk("t6.final_idx", fin, 2);
        chk("t6.no_done", dn_cyc[0].size(), 0);
        run_word(8'h81, 0, "t6b");
        summ(0, cnt, bits, first, fin, lcnt, lpos);
        chk("t6b.first_idx", first, 0);
        chk("t6b.count", cnt, 8);
        summ(2, cnt, bits, first, fin, lcnt, lpos);
        chk("t6b.skip.count", cnt, 2);
        chk("t6b.skip.final_idx", fin, 7);

        // Randomized traffic checked every cycle against the model
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        wait_idle("final");
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
